// File: rtl/out_channel_pkg.sv
// Shared types and helpers for the output-channel arbiter and its round-robin picker.
package out_channel_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    localparam int MEMORY_ELEMENT_WIDTH = 12;

    // Wrap by explicit compare so depths that are not a power of two work.
    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr, wrapping.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_grant
);

    int               sum;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        sum       = 0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            sum = int'(rr_ptr) + k;
            if (sum >= N) sum = sum - N;
            idx = IDX_W'(sum);
            if (!any_grant && req_valid[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/out_channel_arbiter.sv
// Round-robin sharing of one circular output buffer among NReq writers, with finish/drain.
// Optional statistics counters are enabled by defining OUT_CHANNEL_ARBITER_STATS_EN.
module out_channel_arbiter
    import out_channel_pkg::*;
#(
    parameter int MemoryElementWidth = MEMORY_ELEMENT_WIDTH,
    parameter int NReq               = 4,
    parameter int NOut               = 9
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NReq-1:0]                    req_valid,
    input  logic [NReq*MemoryElementWidth-1:0] req_data,
    output logic [NReq-1:0]                    req_ready,
    output logic                               rd_valid,
    output logic [MemoryElementWidth-1:0]      rd_data,
    input  logic                               rd_ready,
    input  logic                               finish_req,
    output logic                               finished,
    output logic [$clog2(NOut+1)-1:0]          count,
    output arb_state_t                         state
`ifdef OUT_CHANNEL_ARBITER_STATS_EN
    ,
    output logic [31:0]                        grant_total,
    output logic [31:0]                        stall_cycles
`endif
);

    localparam int PTR_W = $clog2(NOut);
    localparam int CNT_W = $clog2(NOut + 1);
    localparam int IDX_W = $clog2(NReq);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(NOut);

    logic [MemoryElementWidth-1:0] mem [NOut];
    logic [MemoryElementWidth-1:0] req_word [NReq];

    logic [PTR_W-1:0] wr_pos;
    logic [PTR_W-1:0] rd_pos;
    logic [CNT_W-1:0] count_q;
    logic [IDX_W-1:0] rr_ptr;

    arb_state_t state_q;
    arb_state_t state_d;

    logic [NReq-1:0]  grant;
    logic [IDX_W-1:0] grant_idx;
    logic             any_grant;
    logic             accept_en;
    logic             accept;
    logic             rd_fire;

    always_comb begin
        for (int i = 0; i < NReq; i++) begin
            req_word[i] = req_data[i*MemoryElementWidth +: MemoryElementWidth];
        end
    end

    rr_arbiter #(
        .N     (NReq),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (finish_req) state_d = DRAIN;
            DRAIN:   if (count_q == '0) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    // Output logic; no bypass when full, even if a read is happening this cycle.
    always_comb begin
        accept_en = (state_q == RUN) && (count_q < FULL);
        finished  = (state_q == DONE);
    end

    assign req_ready = accept_en ? grant : '0;
    assign accept    = accept_en && any_grant;
    assign rd_valid  = (count_q != '0);
    assign rd_data   = mem[rd_pos];
    assign rd_fire   = rd_valid && rd_ready;
    assign count     = count_q;
    assign state     = state_q;

    // Buffer storage is intentionally not cleared by reset.
    always_ff @(posedge clock) begin
        if (accept) mem[wr_pos] <= req_word[grant_idx];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_pos  <= '0;
            rd_pos  <= '0;
            count_q <= '0;
            rr_ptr  <= '0;
        end else begin
            if (accept) begin
                wr_pos <= PTR_W'(ptr_inc(int'(wr_pos), NOut));
                rr_ptr <= IDX_W'(ptr_inc(int'(grant_idx), NReq));
            end
            if (rd_fire) rd_pos <= PTR_W'(ptr_inc(int'(rd_pos), NOut));
            case ({accept, rd_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef OUT_CHANNEL_ARBITER_STATS_EN
    logic stall;
    assign stall = (state_q == RUN) && (|req_valid) && (count_q == FULL);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_total  <= '0;
            stall_cycles <= '0;
        end else begin
            if (accept && (grant_total != '1)) grant_total <= grant_total + 1'b1;
            if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_out_channel_arbiter.sv
// Scoreboard bench for out_channel_arbiter: queued expected reads/grants checked by a monitor.
module tb_out_channel_arbiter;
    import out_channel_pkg::*;

    localparam int W  = 12;
    localparam int NR = 4;
    localparam int NO = 9;
    localparam int CW = $clog2(NO + 1);

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*W-1:0]   req_data = '0;
    logic [NR-1:0]     req_ready;
    logic              rd_valid;
    logic [W-1:0]      rd_data;
    logic              rd_ready = 1'b0;
    logic              finish_req = 1'b0;
    logic              finished;
    logic [CW-1:0]     count;
    arb_state_t        state;
`ifdef OUT_CHANNEL_ARBITER_STATS_EN
    logic [31:0]       grant_total;
    logic [31:0]       stall_cycles;
`endif

    int tests = 0;
    int fails = 0;
    logic [W-1:0]  exp_q[$];
    logic [NR-1:0] gnt_q[$];

    out_channel_arbiter #(
        .MemoryElementWidth (W),
        .NReq               (NR),
        .NOut               (NO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_ready     (rd_ready),
        .finish_req   (finish_req),
        .finished     (finished),
        .count        (count),
        .state        (state)
`ifdef OUT_CHANNEL_ARBITER_STATS_EN
        ,
        .grant_total  (grant_total),
        .stall_cycles (stall_cycles)
`endif
    );

    // Clock / reset
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT completes a read or a grant handshake
    always @(negedge clock) begin
        if (!reset) begin
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rd_unexpected: got %0d expected no read", rd_data);
                end else begin
                    check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
                end
            end
            if ((req_valid & req_ready) != '0) begin
                if (gnt_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL grant_unexpected: got %0h expected no grant", req_ready);
                end else begin
                    check("grant", 32'(req_ready), 32'(gnt_q.pop_front()));
                end
            end
        end
    end

    // Driver tasks (called at posedge + 1)
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [W-1:0] v, input logic push);
        logic [NR-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        req_valid[idx] = 1'b1;
        req_data[idx*W +: W] = v;
        if (push) begin
            exp_q.push_back(v);
            gnt_q.push_back(oh);
        end
    endtask

    task automatic write_word(input int idx, input logic [W-1:0] v);
        set_req(idx, v, 1'b1);
        tick();
        req_valid = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        finish_req = 1'b0;
        rd_ready = 1'b0;
        exp_q.delete();
        gnt_q.delete();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_empty(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (count == '0) break;
        end
        check(name, 32'(count), 32'd0);
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_count", 32'(count), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_finished", 32'(finished), 0);
        check("rst_state", 32'(state), 32'(RUN));
        tick();
        reset = 1'b0;

        // Single requester, 1-cycle read latency
        rd_ready = 1'b1;
        for (int v = 1; v <= 3; v++) begin
            write_word(0, W'(v));
            @(negedge clock);
            check("t1_lat_valid", 32'(rd_valid), 1);
            check("t1_lat_data", 32'(rd_data), 32'(v));
            tick();
        end
        @(negedge clock);
        check("empty_ignores_rd_ready", 32'(count), 0);
        check("empty_rd_valid", 32'(rd_valid), 0);

        // Fairness: all requesters valid
        do_reset();
        rd_ready = 1'b1;
        set_req(0, 12'd10, 1'b0);
        set_req(1, 12'd20, 1'b0);
        set_req(2, 12'd30, 1'b0);
        set_req(3, 12'd40, 1'b0);
        exp_q = '{12'd10, 12'd20, 12'd30, 12'd40, 12'd10};
        gnt_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        repeat (5) tick();
        req_valid = '0;
        tick();
        @(negedge clock);
        check("t2_count", 32'(count), 0);
        check("t2_queue_empty", 32'(exp_q.size() + gnt_q.size()), 0);

        // Full, no bypass, wrap
        do_reset();
        rd_ready = 1'b0;
        for (int v = 1; v <= 9; v++) write_word(0, W'(v));
        set_req(0, 12'd33, 1'b1);
        rd_ready = 1'b1;
        @(negedge clock);
        check("full_count", 32'(count), 9);
        check("full_no_bypass", 32'(req_ready), 0);
        tick();
        @(negedge clock);
        check("full_accept_next", 32'(req_ready), 32'(4'b0001));
        check("after_read_count", 32'(count), 8);
        tick();
        req_valid = '0;
        tick();
        rd_ready = 1'b0;
        write_word(0, 12'd22);
        write_word(0, 12'd11);
        @(negedge clock);
        check("refull_count", 32'(count), 9);
        check("refull_ready", 32'(req_ready), 0);
        tick();
        rd_ready = 1'b1;
        wait_empty("t3_drain", 40);
        check("t3_queue_empty", 32'(exp_q.size()), 0);

        // Simultaneous read and write at count 5
        tick();
        rd_ready = 1'b0;
        for (int v = 50; v <= 54; v++) write_word(1, W'(v));
        @(negedge clock);
        check("t4_count5", 32'(count), 5);
        tick();
        rd_ready = 1'b1;
        set_req(2, 12'd55, 1'b1);
        tick();
        req_valid = '0;
        rd_ready = 1'b0;
        @(negedge clock);
        check("t4_simul_count", 32'(count), 5);
        tick();
        rd_ready = 1'b1;
        wait_empty("t4_drain", 40);
        check("t4_queue_empty", 32'(exp_q.size()), 0);

        // Finish with a same-cycle accept
        tick();
        rd_ready = 1'b0;
        for (int v = 60; v <= 62; v++) write_word(3, W'(v));
        @(negedge clock);
        check("t5_count3", 32'(count), 3);
        tick();
        set_req(1, 12'd63, 1'b1);
        finish_req = 1'b1;
        tick();
        finish_req = 1'b0;
        @(negedge clock);
        check("t5_count4", 32'(count), 4);
        check("t5_no_grant", 32'(req_ready), 0);
        check("t5_state_drain", 32'(state), 32'(DRAIN));
        check("t5_not_finished", 32'(finished), 0);
        tick();
        rd_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (finished) break;
        end
        check("t5_finished", 32'(finished), 1);
        tick();
        finish_req = 1'b1;
        tick();
        finish_req = 1'b0;
        repeat (3) tick();
        @(negedge clock);
        check("t5_finished_sticky", 32'(finished), 1);
        check("t5_state_done", 32'(state), 32'(DONE));
        check("t5_done_no_grant", 32'(req_ready), 0);
        check("t5_done_count", 32'(count), 0);
        check("t5_queue_empty", 32'(exp_q.size() + gnt_q.size()), 0);
        tick();
        req_valid = '0;

        // Reset asserted mid-DRAIN
        do_reset();
        write_word(0, 12'd70);
        write_word(0, 12'd71);
        finish_req = 1'b1;
        tick();
        finish_req = 1'b0;
        @(negedge clock);
        check("t6_state_drain", 32'(state), 32'(DRAIN));
        tick();
        reset = 1'b1;
        exp_q.delete();
        gnt_q.delete();
        #1;
        check("t6_rst_finished", 32'(finished), 0);
        check("t6_rst_count", 32'(count), 0);
        check("t6_rst_state", 32'(state), 32'(RUN));
        check("t6_rst_rd_valid", 32'(rd_valid), 0);
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
